// File: rtl/mult32x32_pkg.sv
// mult32x32_pkg: shared types and step helpers for the 32x32 multiplier sequencer
package mult32x32_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam int NUM_STEPS = 8;
  typedef logic [2:0] step_t;
  function automatic logic [2:0] shift_of(step_t k);
    return {1'b0, k[1:0]} + {1'b0, k[2], 1'b0};
  endfunction
endpackage

// File: rtl/mult32x32_next_step.sv
// mult32x32_next_step: finds the lowest enabled step at or after a start index
module mult32x32_next_step
  import mult32x32_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic [NUM_STEPS-1:0] mask,
  input  step_t                start,
  input  logic                 inclusive,
  output step_t                idx_next,
  output logic                 found
);
  logic [NUM_STEPS-1:0] eff;
  assign eff = SKIP_ZERO ? mask : {NUM_STEPS{1'b1}};
  // descending scan so the lowest qualifying index wins
  always_comb begin
    idx_next = '0;
    found = 1'b0;
    for (int i = NUM_STEPS - 1; i >= 0; i--)
      if (eff[i] && (i > int'(start) || (inclusive && i == int'(start)))) begin
        idx_next = step_t'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl: sequences clear and byte x half-word accumulate steps for the arith unit
module mult32x32_ctrl
  import mult32x32_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [1:0]  a_sel,
  output logic        b_sel,
  output logic [2:0]  shift_sel,
  output logic        upd_prod,
  output logic        clr_prod,
  output logic        busy,
  output logic        done
);
  state_t               state, state_d;
  step_t                idx, idx_d, nxt, start_idx;
  logic [NUM_STEPS-1:0] mask, mask_in;
  logic                 found, accept, run;
  assign run = state == RUN;
  assign accept = in_valid & in_ready;
  assign start_idx = run ? idx : '0;
  mult32x32_next_step #(.SKIP_ZERO(SKIP_ZERO)) u_next (
    .mask     (mask),
    .start    (start_idx),
    .inclusive(!run),
    .idx_next (nxt),
    .found    (found)
  );
  // a step is useful only if both its a byte and its b half are non-zero
  always_comb begin
    mask_in = '0;
    for (int k = 0; k < NUM_STEPS; k++)
      mask_in[k] = (a_in[8*(k%4) +: 8] != 8'd0) && (b_in[16*(k/4) +: 16] != 16'd0);
  end
  // next state and step index
  always_comb begin
    state_d = state == IDLE ? (accept ? CLEAR : IDLE) :
              state == DONE ? IDLE :
              found ? RUN : DONE;
    idx_d = (state == CLEAR || run) && found ? nxt : idx;
  end
  // state, step index and held operands
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      mask <= '0;
      a <= '0;
      b <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      if (accept) begin
        a <= a_in;
        b <= b_in;
        mask <= mask_in;
      end
    end
  end
  assign in_ready = state == IDLE;
  assign clr_prod = state == CLEAR;
  assign upd_prod = run;
  assign busy = state == CLEAR || run;
  assign done = state == DONE;
  assign a_sel = run ? idx[1:0] : 2'd0;
  assign b_sel = run ? idx[2] : 1'b0;
  assign shift_sel = run ? shift_of(idx) : 3'd0;
endmodule

// File: tb/tb_mult32x32_ctrl.sv
// tb_mult32x32_ctrl: checks both SKIP_ZERO variants against a behavioural arith unit and a product scoreboard
module tb_mult32x32_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [1:0]  in_ready, b_sel, upd_prod, clr_prod, busy, done;
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [1:0]  a_sel [2];
  logic [2:0]  shift_sel [2];
  logic [63:0] prod0, prod1;
  int          cyc = 0;
  int          asserts = 0;
  int          fails = 0;
  logic [63:0] q_prod0[$], q_prod1[$];
  int          q_cyc0[$], q_cyc1[$];
  logic [63:0] ep;
  int          ec;

  mult32x32_ctrl #(.SKIP_ZERO(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a_in(a_in), .b_in(b_in), .a(a[0]), .b(b[0]), .a_sel(a_sel[0]), .b_sel(b_sel[0]),
    .shift_sel(shift_sel[0]), .upd_prod(upd_prod[0]), .clr_prod(clr_prod[0]),
    .busy(busy[0]), .done(done[0])
  );
  mult32x32_ctrl #(.SKIP_ZERO(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a_in(a_in), .b_in(b_in), .a(a[1]), .b(b[1]), .a_sel(a_sel[1]), .b_sel(b_sel[1]),
    .shift_sel(shift_sel[1]), .upd_prod(upd_prod[1]), .clr_prod(clr_prod[1]),
    .busy(busy[1]), .done(done[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pp(logic [31:0] x, logic [31:0] y, logic [1:0] as, logic bs, logic [2:0] sh);
    logic [63:0] t;
    t = 64'(x[8*as +: 8]) * 64'(y[16*bs +: 16]);
    return t << (8 * sh);
  endfunction

  function automatic int exp_n(logic [31:0] x, logic [31:0] y);
    int n = 0;
    for (int h = 0; h < 2; h++)
      for (int j = 0; j < 4; j++)
        if (x[8*j +: 8] != 0 && y[16*h +: 16] != 0) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      prod0 <= '0;
      prod1 <= '0;
    end else begin
      if (clr_prod[0]) prod0 <= '0;
      else if (upd_prod[0]) prod0 <= prod0 + pp(a[0], b[0], a_sel[0], b_sel[0], shift_sel[0]);
      if (clr_prod[1]) prod1 <= '0;
      else if (upd_prod[1]) prod1 <= prod1 + pp(a[1], b[1], a_sel[1], b_sel[1], shift_sel[1]);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q_prod0.delete(); q_cyc0.delete(); q_prod1.delete(); q_cyc1.delete();
    end else begin
      if (in_valid && in_ready[0]) begin
        q_prod0.push_back(64'(a_in) * 64'(b_in));
        q_cyc0.push_back(cyc + 10);
      end
      if (in_valid && in_ready[1]) begin
        q_prod1.push_back(64'(a_in) * 64'(b_in));
        q_cyc1.push_back(cyc + 2 + exp_n(a_in, b_in));
      end
      if (done[0]) begin
        asserts++;
        if (q_prod0.size() == 0) begin
          fails++;
          $display("FAIL done0_unexpected: done=1 at cyc %0d, required no pending transaction", cyc);
        end else begin
          ep = q_prod0.pop_front();
          ec = q_cyc0.pop_front();
          if (prod0 !== ep) begin
            fails++;
            $display("FAIL product0: got %h, required %h", prod0, ep);
          end
          asserts++;
          if (cyc !== ec) begin
            fails++;
            $display("FAIL latency0: done at cyc %0d, required %0d", cyc, ec);
          end
        end
      end
      if (done[1]) begin
        asserts++;
        if (q_prod1.size() == 0) begin
          fails++;
          $display("FAIL done1_unexpected: done=1 at cyc %0d, required no pending transaction", cyc);
        end else begin
          ep = q_prod1.pop_front();
          ec = q_cyc1.pop_front();
          if (prod1 !== ep) begin
            fails++;
            $display("FAIL product1: got %h, required %h", prod1, ep);
          end
          asserts++;
          if (cyc !== ec) begin
            fails++;
            $display("FAIL latency1: done at cyc %0d, required %0d", cyc, ec);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 2'b11 && n < 50) begin
      tick();
      n++;
    end
    asserts++;
    if (in_ready !== 2'b11) begin
      fails++;
      $display("FAIL wait_idle: in_ready=%b, required 11", in_ready);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    a_in = x;
    b_in = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic observe(input int i, input int n, output int nupd, output int clr_c,
                         output int done_c, output logic [23:0] sh, output logic [2:0] sel);
    nupd = 0; clr_c = -1; done_c = -1; sh = '0; sel = '0;
    for (int c = 1; c <= n; c++) begin
      if (clr_prod[i] && clr_c < 0) clr_c = c;
      if (upd_prod[i]) begin
        if (nupd < 8) sh[3*nupd +: 3] = shift_sel[i];
        sel = {b_sel[i], a_sel[i]};
        nupd++;
      end
      if (done[i] && done_c < 0) done_c = c;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    asserts++;
    if (in_ready !== 2'b11 || busy !== 2'b00 || done !== 2'b00 || upd_prod !== 2'b00 || clr_prod !== 2'b00) begin
      fails++;
      $display("FAIL reset_ctrl: rdy=%b busy=%b done=%b upd=%b clr=%b, required 11 00 00 00 00",
               in_ready, busy, done, upd_prod, clr_prod);
    end
    asserts++;
    if (a[0] !== 32'd0 || b[0] !== 32'd0 || a_sel[0] !== 2'd0 || shift_sel[0] !== 3'd0 || b_sel !== 2'b00) begin
      fails++;
      $display("FAIL reset_data: a=%h b=%h a_sel=%0d shift=%0d b_sel=%b, required zeros",
               a[0], b[0], a_sel[0], shift_sel[0], b_sel);
    end
  endtask

  task automatic test_full();
    int nupd, clr_c, done_c;
    logic [23:0] sh;
    logic [2:0] sel;
    wait_idle();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    observe(0, 11, nupd, clr_c, done_c, sh, sel);
    asserts++;
    if (nupd !== 8) begin fails++; $display("FAIL full_upd_count: got %0d, required 8", nupd); end
    asserts++;
    if (clr_c !== 1) begin fails++; $display("FAIL full_clr_cycle: got %0d, required 1", clr_c); end
    asserts++;
    if (done_c !== 10) begin fails++; $display("FAIL full_done_cycle: got %0d, required 10", done_c); end
    asserts++;
    if (sh !== {3'd5, 3'd4, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0}) begin
      fails++;
      $display("FAIL full_shift_seq: got %h, required %h", sh, {3'd5, 3'd4, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0});
    end
  endtask

  task automatic test_skip(input logic [31:0] x, input logic [31:0] y, input int e_upd,
                           input int e_done, input logic [2:0] e_sel, input logic [2:0] e_sh);
    int nupd, clr_c, done_c;
    logic [23:0] sh;
    logic [2:0] sel;
    wait_idle();
    send(x, y);
    observe(1, 5, nupd, clr_c, done_c, sh, sel);
    asserts++;
    if (nupd !== e_upd) begin fails++; $display("FAIL skip_upd_count %h*%h: got %0d, required %0d", x, y, nupd, e_upd); end
    asserts++;
    if (clr_c !== 1) begin fails++; $display("FAIL skip_clr_cycle %h*%h: got %0d, required 1", x, y, clr_c); end
    asserts++;
    if (done_c !== e_done) begin fails++; $display("FAIL skip_done_cycle %h*%h: got %0d, required %0d", x, y, done_c, e_done); end
    if (e_upd == 1) begin
      asserts++;
      if (sel !== e_sel || sh[2:0] !== e_sh) begin
        fails++;
        $display("FAIL skip_selects %h*%h: sel=%b shift=%0d, required sel=%b shift=%0d", x, y, sel, sh[2:0], e_sel, e_sh);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    a_in = 32'hCAFE_0123;
    b_in = 32'h0BAD_F00D;
    in_valid = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      a_in = $urandom;
      b_in = $urandom;
      asserts++;
      if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL b2b_ready_busy c=%0d: got %b, required 0", c, in_ready[0]); end
      asserts++;
      if (a[0] !== 32'hCAFE_0123 || b[0] !== 32'h0BAD_F00D) begin
        fails++;
        $display("FAIL b2b_hold c=%0d: a=%h b=%h, required cafe0123 0badf00d", c, a[0], b[0]);
      end
      tick();
    end
    asserts++;
    if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready_idle: got %b, required 1", in_ready[0]); end
    a_in = 32'h1357_9BDF;
    b_in = 32'h2468_ACE0;
    tick();
    in_valid = 1'b0;
    asserts++;
    if (a[0] !== 32'h1357_9BDF || b[0] !== 32'h2468_ACE0) begin
      fails++;
      $display("FAIL b2b_second_accept: a=%h b=%h, required 13579bdf 2468ace0", a[0], b[0]);
    end
  endtask

  task automatic test_abort();
    int nupd, clr_c, done_c;
    logic [23:0] sh;
    logic [2:0] sel;
    int seen = 0;
    wait_idle();
    send(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    asserts++;
    if (in_ready !== 2'b11 || busy !== 2'b00 || done !== 2'b00 || upd_prod !== 2'b00 || clr_prod !== 2'b00 ||
        a[0] !== 32'd0 || b[0] !== 32'd0 || a_sel[0] !== 2'd0 || shift_sel[0] !== 3'd0) begin
      fails++;
      $display("FAIL abort_outputs: rdy=%b busy=%b done=%b upd=%b clr=%b a=%h b=%h, required idle zeros",
               in_ready, busy, done, upd_prod, clr_prod, a[0], b[0]);
    end
    for (int c = 0; c < 12; c++) begin
      if (done !== 2'b00) seen++;
      tick();
    end
    asserts++;
    if (seen !== 0) begin fails++; $display("FAIL abort_no_done: got %0d done cycles, required 0", seen); end
    send(32'hDEAD_BEEF, 32'h0000_FFFF);
    observe(0, 11, nupd, clr_c, done_c, sh, sel);
    asserts++;
    if (done_c !== 10 || nupd !== 8) begin
      fails++;
      $display("FAIL abort_recover: done at %0d with %0d steps, required 10 and 8", done_c, nupd);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_skip(32'h0000_0003, 32'h0000_0005, 1, 3, 3'b000, 3'd0);
    test_skip(32'h0000_0000, 32'h1234_5678, 0, 2, 3'b000, 3'd0);
    test_skip(32'h0100_0000, 32'h0001_0000, 1, 3, 3'b111, 3'd5);
    test_full();
    test_back_to_back();
    test_abort();
    test_skip(32'hFF00_00FF, 32'h0000_8001, 2, 4, 3'b011, 3'd3);
    wait_idle();
    repeat (2) tick();
    asserts++;
    if (q_prod0.size() != 0 || q_prod1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d/%0d pending, required 0/0", q_prod0.size(), q_prod1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
